// File: rtl/xor_nand_sequencer.sv
// xor_nand_sequencer: computes a ^ b by issuing the four-NAND XOR network
// (t1 = ~(a&b), t3 = ~(a&t1), t4 = ~(b&t1), s = ~(t3&t4)) one NAND per cycle
// through a single external combinational NAND array.
// Optional feature: define XOR_NAND_SEQUENCER_STATS_EN to add an 8-bit
// op_count output that counts completed operations.
module xor_nand_sequencer #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] nand_x,
   output logic [WIDTH-1:0] nand_y,
   input  logic [WIDTH-1:0] nand_s,
   output logic             busy,
   output logic             done,
`ifdef XOR_NAND_SEQUENCER_STATS_EN
   output logic [7:0]       op_count,
`endif
   output logic [WIDTH-1:0] s
);

   typedef enum logic [2:0] {
      StIdle = 3'd0,
      StS1   = 3'd1,
      StS2   = 3'd2,
      StS3   = 3'd3,
      StS4   = 3'd4,
      StDone = 3'd5
   } state_e;

   state_e state_q, state_d;

   logic [WIDTH-1:0] ra_q, rb_q, t1_q, t3_q, t4_q, s_q;

   // Start is only honoured when no operation is in flight.
   logic accept;
   assign accept = start && ((state_q == StIdle) || (state_q == StDone));

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: fixed four-step walk, DONE may chain straight into S1.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  state_d = start ? StS1 : StIdle;
         StS1:    state_d = StS2;
         StS2:    state_d = StS3;
         StS3:    state_d = StS4;
         StS4:    state_d = StDone;
         StDone:  state_d = start ? StS1 : StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Output decode: NAND operand routing and handshake flags per state.
   always_comb begin
      nand_x = '0;
      nand_y = '0;
      busy   = 1'b0;
      done   = 1'b0;
      unique case (state_q)
         StS1: begin
            nand_x = ra_q;
            nand_y = rb_q;
            busy   = 1'b1;
         end
         StS2: begin
            nand_x = ra_q;
            nand_y = t1_q;
            busy   = 1'b1;
         end
         StS3: begin
            nand_x = rb_q;
            nand_y = t1_q;
            busy   = 1'b1;
         end
         StS4: begin
            nand_x = t3_q;
            nand_y = t4_q;
            busy   = 1'b1;
         end
         StDone:  done = 1'b1;
         default: ;
      endcase
   end

   // Operand capture and intermediate/result storage from the shared NAND.
   always_ff @(posedge clk) begin
      if (reset) begin
         ra_q <= '0;
         rb_q <= '0;
         t1_q <= '0;
         t3_q <= '0;
         t4_q <= '0;
         s_q  <= '0;
      end else begin
         if (accept) begin
            ra_q <= a;
            rb_q <= b;
         end
         if (state_q == StS1) t1_q <= nand_s;
         if (state_q == StS2) t3_q <= nand_s;
         if (state_q == StS3) t4_q <= nand_s;
         if (state_q == StS4) s_q  <= nand_s;
      end
   end

   assign s = s_q;

`ifdef XOR_NAND_SEQUENCER_STATS_EN
   logic [7:0] op_count_q;

   // Completion counter; wraps naturally at 8 bits, aborted ops never reach S4->DONE.
   always_ff @(posedge clk) begin
      if (reset) begin
         op_count_q <= '0;
      end else if (state_q == StS4) begin
         op_count_q <= op_count_q + 8'd1;
      end
   end

   assign op_count = op_count_q;
`endif

endmodule

// File: tb/tb_xor_nand_sequencer.sv
// Directed bench for xor_nand_sequencer: a WIDTH=4 instance for the main
// scenarios and a WIDTH=1 instance for the exhaustive XOR truth table.
module tb_xor_nand_sequencer;

   logic clk = 1'b0;
   logic reset = 1'b1;

   logic       start = 1'b0;
   logic [3:0] a = '0, b = '0;
   logic [3:0] nand_x, nand_y, nand_s, s;
   logic       busy, done;

   logic       start1 = 1'b0;
   logic [0:0] a1 = '0, b1 = '0;
   logic [0:0] nand_x1, nand_y1, nand_s1, s1;
   logic       busy1, done1;

`ifdef XOR_NAND_SEQUENCER_STATS_EN
   logic [7:0] op_count, op_count1;
`endif

   int total = 0;
   int bad = 0;
   int done_seen;

   always #5 clk = ~clk;

   // External NAND arrays modelled in the bench.
   assign nand_s  = ~(nand_x & nand_y);
   assign nand_s1 = ~(nand_x1 & nand_y1);

   xor_nand_sequencer #(.WIDTH(4)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .a        (a),
      .b        (b),
      .nand_x   (nand_x),
      .nand_y   (nand_y),
      .nand_s   (nand_s),
      .busy     (busy),
      .done     (done),
`ifdef XOR_NAND_SEQUENCER_STATS_EN
      .op_count (op_count),
`endif
      .s        (s)
   );

   xor_nand_sequencer #(.WIDTH(1)) dut1 (
      .clk      (clk),
      .reset    (reset),
      .start    (start1),
      .a        (a1),
      .b        (b1),
      .nand_x   (nand_x1),
      .nand_y   (nand_y1),
      .nand_s   (nand_s1),
      .busy     (busy1),
      .done     (done1),
`ifdef XOR_NAND_SEQUENCER_STATS_EN
      .op_count (op_count1),
`endif
      .s        (s1)
   );

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; outputs are then sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      tick();
      tick();
      reset = 1'b0;
      check("rst_busy", 8'(busy), 8'h0);
      check("rst_done", 8'(done), 8'h0);
      check("rst_s", 8'(s), 8'h0);
      check("rst_nx", 8'(nand_x), 8'h0);
      check("rst_ny", 8'(nand_y), 8'h0);

      // Single operation 0011 ^ 0101, operand pairs checked each step.
      a = 4'b0011; b = 4'b0101; start = 1'b1;
      tick();
      start = 1'b0; a = 4'b0000; b = 4'b0000;
      check("s1_busy", 8'(busy), 8'h1);
      check("s1_pair", {nand_x, nand_y}, 8'b0011_0101);
      tick();
      check("s2_pair", {nand_x, nand_y}, 8'b0011_1110);
      tick();
      check("s3_pair", {nand_x, nand_y}, 8'b0101_1110);
      tick();
      check("s4_pair", {nand_x, nand_y}, 8'b1101_1011);
      check("s4_busy", 8'(busy), 8'h1);
      check("s4_done", 8'(done), 8'h0);
      tick();
      check("dn_done", 8'(done), 8'h1);
      check("dn_busy", 8'(busy), 8'h0);
      check("dn_s", 8'(s), 8'b0110);
      check("dn_pair", {nand_x, nand_y}, 8'h00);
      tick();
      check("idle_done", 8'(done), 8'h0);
      check("hold_s", 8'(s), 8'b0110);

      // Back-to-back with start held high; mid-op operand changes ignored.
      a = 4'b1111; b = 4'b1111; start = 1'b1;
      tick();
      a = 4'b0110; b = 4'b0011;
      tick();
      tick();
      check("b2b_ign_pair", {nand_x, nand_y}, 8'b1111_0000);
      tick();
      a = 4'b1010; b = 4'b0000;
      check("b2b_s4_done", 8'(done), 8'h0);
      tick();
      check("b2b1_done", 8'(done), 8'h1);
      check("b2b1_s", 8'(s), 8'b0000);
      tick();
      check("b2b2_s1_busy", 8'(busy), 8'h1);
      check("b2b2_s1_pair", {nand_x, nand_y}, 8'b1010_0000);
      done_seen = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (done) done_seen++;
      end
      check("b2b2_nodone", 8'(done_seen), 8'h0);
      start = 1'b0;
      tick();
      check("b2b2_done", 8'(done), 8'h1);
      check("b2b2_s", 8'(s), 8'b1010);
      tick();
      check("b2b_idle", 8'(busy | done), 8'h0);

      // Start asserted while busy is neither queued nor re-captures operands.
      a = 4'b0011; b = 4'b0101; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      start = 1'b1; a = 4'b1111; b = 4'b0000;
      tick();
      check("ign_s3_pair", {nand_x, nand_y}, 8'b0101_1110);
      tick();
      start = 1'b0;
      tick();
      check("ign_done", 8'(done), 8'h1);
      check("ign_s", 8'(s), 8'b0110);
      tick();
      check("ign_idle", 8'(busy | done), 8'h0);

      // Reset during S3 abandons the operation.
      a = 4'b1100; b = 4'b1010; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      check("rm_in_s3", {nand_x, nand_y}, 8'b1010_0111);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("rm_busy", 8'(busy), 8'h0);
      check("rm_done", 8'(done), 8'h0);
      check("rm_s", 8'(s), 8'h0);
      check("rm_pair", {nand_x, nand_y}, 8'h00);
      done_seen = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (done || busy) done_seen++;
      end
      check("rm_quiet", 8'(done_seen), 8'h0);
      a = 4'b1100; b = 4'b1010; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) tick();
      check("rm_new_done", 8'(done), 8'h1);
      check("rm_new_s", 8'(s), 8'b0110);
      tick();

      // Exhaustive 1-bit truth table on the WIDTH=1 instance.
      for (int i = 0; i < 4; i++) begin
         logic [1:0] ab;
         ab = 2'(i);
         a1 = ab[1]; b1 = ab[0]; start1 = 1'b1;
         tick();
         start1 = 1'b0;
         repeat (4) tick();
         check($sformatf("w1_done_%0d", i), 8'(done1), 8'h1);
         check($sformatf("w1_s_%0d", i), 8'(s1), 8'(ab[1] ^ ab[0]));
         tick();
      end

`ifdef XOR_NAND_SEQUENCER_STATS_EN
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("cnt_rst", op_count, 8'd0);
      a = 4'b0001; b = 4'b0010; start = 1'b1;
      tick();
      for (int i = 0; i < 257; i++) begin
         repeat (4) tick();
         if (i == 256) start = 1'b0;
         tick();
      end
      check("cnt_wrap", op_count, 8'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("cnt_clr", op_count, 8'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Global time bound so the run can never hang.
   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
